mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle sequencing controller for the single-issue processor datapath (imem, regfile, ALU, dmem).
- Replaces the skewed multi-clock scheme with one clock and per-phase enables.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Redirects add/addi/sub overflow results to the status register ($30).

Parameters:
- OPW, 5, opcode and ALU-op field width
- RW, 5, register address width
- STATUS_REG, 30, register index written on overflow
- CNT_W, 32, width of the optional performance counters

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; allows new instruction fetch
- instr  in  32  imem read data, valid in FETCH
- dmem_ready  in  1  dmem read/write complete
- alu_ovf  in  1  ALU overflow flag, valid in EXEC
- pc_en  out  1  PC advance strobe
- ir_load  out  1  latch instruction
- rf_re  out  1  regfile read enable
- alu_en  out  1  ALU operand register enable
- dmem_re  out  1  dmem read request
- dmem_we  out  1  dmem write request
- rf_we  out  1  regfile write enable
- rf_waddr  out  RW  regfile write address
- wb_sel  out  2  writeback mux select: 0 ALU, 1 mem, 2 status
- status_val  out  32  value written on overflow
- illegal  out  1  one-cycle pulse on an undefined opcode
- state_o  out  3  current state, for debug

Behaviour:
- Decode fields: instr[31:27] opcode, [26:22] rd, [6:2] ALU op.
- Opcodes:
  - 00000 R-type
  - 00101 addi
  - 00111 sw
  - 01000 lw
  - anything else is illegal.
- R-type ALU ops: add 00000, sub 00001, and 00010, or 00011, sll 00100, sra 00101.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- State transitions:
  - IDLE -> FETCH when run=1.
  - FETCH -> DECODE always. In FETCH: ir_load=1, pc_en=1, and opcode/rd/aluop are latched internally.
  - DECODE (rf_re=1) -> EXEC for legal opcodes.
  - DECODE -> FETCH (IDLE if run=0) for illegal opcodes, with illegal=1 for that cycle and no writes.
  - EXEC (alu_en=1) -> WB for R-type and addi.
  - EXEC -> MEM for lw and sw.
  - MEM holds dmem_re (lw) or dmem_we (sw) until dmem_ready=1.
  - MEM with dmem_ready: lw -> WB; sw -> FETCH (IDLE if run=0).
  - WB (rf_we) -> FETCH if run=1, else IDLE.
- Latency: R-type/addi 4 cycles, sw 4+waits, lw 5+waits.
- All strobes are decoded from the registered state (Moore).
- rf_waddr, wb_sel and status_val are registered at the EXEC->WB transition.
- Overflow:
  - alu_ovf is sampled on the last EXEC cycle.
  - If it is set for add, addi or sub: rf_waddr=STATUS_REG, wb_sel=2, status_val=1 (add), 2 (addi) or 3 (sub).
  - alu_ovf is ignored for every other op.
- Writeback rules:
  - Normal writeback: rf_waddr=rd, wb_sel=0 (ALU) or 1 (lw).
  - If rd=0 and no overflow redirect, rf_we is suppressed in WB; the state still passes through WB.
- run deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.
- dmem_ready outside MEM is ignored.
- Reset (reset=0) at any time: asynchronous return to IDLE; all outputs 0; rf_waddr=0, wb_sel=0, status_val=0. No partial write completes.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cycle_cnt[CNT_W-1:0]: increments every cycle while not in IDLE.
  - retire_cnt[CNT_W-1:0]: increments on WB exit and on sw MEM exit with dmem_ready.
- Both counters wrap modulo 2^CNT_W and are cleared by reset.
- Illegal instructions do not retire.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package mc_pkg holds:
  - the state enum
  - opcode and ALU-op localparams
  - wb_sel encodings
  - status codes 1/2/3
  - the STATUS_REG default
- Natural sub-module: mc_decode, a combinational decoder from opcode/aluop to {is_alu, is_imm, is_lw, is_sw, ovf_code, legal}.
- The FSM, registers and counters stay in mc_ctrl.

Test Plan:
- Reset held 2 cycles, then run=1 with instr addi $1,$0,5 (0x28400005) -> state sequence 1,2,3,5; in WB rf_we=1, rf_waddr=1, wb_sel=0; pc_en high exactly once.
- add $21,$20,$20 with alu_ovf=1 in EXEC -> WB with rf_waddr=30, wb_sel=2, status_val=1. Repeat for addi (2) and sub (3). sll with alu_ovf=1 -> normal rd write.
- lw with dmem_ready low for 3 MEM cycles -> dmem_re held 4 cycles, then WB with wb_sel=1. sw -> dmem_we until ready, then FETCH with no rf_we.
- Opcode 11111 -> illegal=1 for one DECODE cycle, no rf_we/dmem_we, next state FETCH. Add with rd=0 -> rf_we stays 0.
- run dropped during EXEC -> WB completes, then IDLE. reset asserted in MEM -> immediate IDLE, dmem_we=0 that same cycle.
- With MC_CTRL_PERF_CNT_EN: 3 ALU instructions + 1 sw (no wait) from reset -> retire_cnt=4, cycle_cnt=16.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: states, opcodes,
// ALU ops, writeback selects, overflow status codes and the decoder result struct.
package mc_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_STATUS = 2'd2;

    // Overflow status codes; OVF_NONE marks ops whose overflow flag is ignored.
    localparam logic [1:0] OVF_NONE = 2'd0;
    localparam logic [1:0] OVF_ADD  = 2'd1;
    localparam logic [1:0] OVF_ADDI = 2'd2;
    localparam logic [1:0] OVF_SUB  = 2'd3;

    localparam int STATUS_REG_DEF = 30;

    typedef struct packed {
        logic       is_alu;
        logic       is_imm;
        logic       is_lw;
        logic       is_sw;
        logic [1:0] ovf_code;
        logic       legal;
    } dec_t;

    function automatic logic [31:0] status_word(input logic [1:0] code);
        return {30'd0, code};
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode / ALU-op decoder for mc_ctrl.
module mc_decode
    import mc_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] alu_op,
    output dec_t           dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.is_alu = 1'b1;
                dec.legal  = 1'b1;
                if (alu_op == ALU_ADD) begin
                    dec.ovf_code = OVF_ADD;
                end else if (alu_op == ALU_SUB) begin
                    dec.ovf_code = OVF_SUB;
                end else begin
                    dec.ovf_code = OVF_NONE;
                end
            end
            OP_ADDI: begin
                dec.is_imm   = 1'b1;
                dec.legal    = 1'b1;
                dec.ovf_code = OVF_ADDI;
            end
            OP_LW: begin
                dec.is_lw = 1'b1;
                dec.legal = 1'b1;
            end
            OP_SW: begin
                dec.is_sw = 1'b1;
                dec.legal = 1'b1;
            end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Single-clock multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) with Moore strobes.
// Optional performance counters are enabled with MC_CTRL_PERF_CNT_EN.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int OPW        = 5,
    parameter int RW         = 5,
    parameter int STATUS_REG = STATUS_REG_DEF,
    parameter int CNT_W      = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic [31:0]   instr,
    input  logic          dmem_ready,
    input  logic          alu_ovf,
    output logic          pc_en,
    output logic          ir_load,
    output logic          rf_re,
    output logic          alu_en,
    output logic          dmem_re,
    output logic          dmem_we,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [1:0]    wb_sel,
    output logic [31:0]   status_val,
    output logic          illegal,
    output logic [2:0]    state_o
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    localparam logic [RW-1:0] STATUS_ADDR = RW'(STATUS_REG);

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [OPW-1:0] opcode_q;
    logic [OPW-1:0] aluop_q;
    logic [RW-1:0]  rd_q;
    logic           wr_ok;
    logic           redirect;
    dec_t           dec;

    logic unused_instr;
    assign unused_instr = ^{instr[21:7], instr[1:0]};

    mc_decode #(.OPW(OPW)) u_decode (
        .opcode (opcode_q),
        .alu_op (aluop_q),
        .dec    (dec)
    );

    assign redirect = alu_ovf && (dec.ovf_code != OVF_NONE);

    // dmem handshake: the request (dmem_re/dmem_we) stays high for every MEM
    // cycle; dmem_ready completes it only while in MEM and is ignored elsewhere.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = run ? S_FETCH : S_IDLE;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (dec.legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = run ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC:   state_nxt = (dec.is_lw || dec.is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    if (dec.is_lw) begin
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opcode_q <= '0;
            aluop_q  <= '0;
            rd_q     <= '0;
        end else if (state == S_FETCH) begin
            opcode_q <= instr[31 -: OPW];
            rd_q     <= instr[26 -: RW];
            aluop_q  <= instr[2 +: OPW];
        end
    end

    // Writeback target is fixed when EXEC ends; lw carries it through MEM unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_waddr   <= '0;
            wb_sel     <= WB_ALU;
            status_val <= '0;
            wr_ok      <= 1'b0;
        end else if (state == S_EXEC) begin
            if (redirect) begin
                rf_waddr   <= STATUS_ADDR;
                wb_sel     <= WB_STATUS;
                status_val <= status_word(dec.ovf_code);
                wr_ok      <= 1'b1;
            end else begin
                rf_waddr   <= rd_q;
                wb_sel     <= dec.is_lw ? WB_MEM : WB_ALU;
                status_val <= '0;
                wr_ok      <= (rd_q != '0) && !dec.is_sw;
            end
        end
    end

    assign pc_en   = (state == S_FETCH);
    assign ir_load = (state == S_FETCH);
    assign rf_re   = (state == S_DECODE);
    assign illegal = (state == S_DECODE) && !dec.legal;
    assign alu_en  = (state == S_EXEC);
    assign dmem_re = (state == S_MEM) && dec.is_lw;
    assign dmem_we = (state == S_MEM) && dec.is_sw;
    assign rf_we   = (state == S_WB) && wr_ok;
    assign state_o = state;

`ifdef MC_CTRL_PERF_CNT_EN
    logic retire;
    assign retire = (state == S_WB) || ((state == S_MEM) && dec.is_sw && dmem_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state != S_IDLE) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed table-driven bench for mc_ctrl plus hand sequences for run drop,
// reset during MEM and (with MC_CTRL_PERF_CNT_EN) the performance counters.
module tb_mc_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] instr;
    logic        dmem_ready;
    logic        alu_ovf;
    logic        pc_en, ir_load, rf_re, alu_en, dmem_re, dmem_we, rf_we, illegal;
    logic [4:0]  rf_waddr;
    logic [1:0]  wb_sel;
    logic [31:0] status_val;
    logic [2:0]  state_o;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mc_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .instr      (instr),
        .dmem_ready (dmem_ready),
        .alu_ovf    (alu_ovf),
        .pc_en      (pc_en),
        .ir_load    (ir_load),
        .rf_re      (rf_re),
        .alu_en     (alu_en),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .wb_sel     (wb_sel),
        .status_val (status_val),
        .illegal    (illegal),
        .state_o    (state_o)
`ifdef MC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    typedef struct {
        logic [31:0] ins;
        bit          ovf;
        int          waits;
        logic [23:0] trace;
        int          we;
        logic [4:0]  wa;
        logic [1:0]  ws;
        logic [31:0] sv;
        int          dre;
        int          dwe;
        int          ill;
    } vec_t;

    vec_t vt[16];

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] aop);
        return {op, rd, 15'd0, aop, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Runs one instruction from its FETCH cycle until the FSM next reaches FETCH or IDLE.
    task automatic exec_instr(input logic [31:0] ins, input bit ovf, input int waits,
                              input bit drop_run, output logic [23:0] trace,
                              output int n_pc, output int n_we, output int n_dre,
                              output int n_dwe, output int n_ill, output logic [4:0] wa,
                              output logic [1:0] ws, output logic [31:0] sv);
        int guard = 0;
        int n_cyc = 0;
        int mem   = 0;
        trace = '0; n_pc = 0; n_we = 0; n_dre = 0; n_dwe = 0; n_ill = 0;
        wa = '0; ws = '0; sv = '0;
        instr = ins;
        alu_ovf = 1'b0;
        while (state_o != 3'd1 && guard < 8) begin
            @(negedge clock);
            guard++;
        end
        chk("fetch_reached", 32'(guard < 8), 32'd1);
        while (n_cyc < 20) begin
            if (n_cyc > 0 && (state_o == 3'd1 || state_o == 3'd0)) break;
            trace = {trace[20:0], state_o};
            n_cyc++;
            if (pc_en) n_pc++;
            if (dmem_re) n_dre++;
            if (dmem_we) n_dwe++;
            if (illegal) n_ill++;
            if (rf_we) begin
                n_we++;
                wa = rf_waddr;
                ws = wb_sel;
                sv = status_val;
            end
            alu_ovf = (state_o == 3'd3) ? ovf : 1'b0;
            if (state_o == 3'd4) begin
                dmem_ready = (mem == waits);
                mem++;
            end else begin
                dmem_ready = 1'b1;
            end
            if (drop_run && state_o == 3'd3) run = 1'b0;
            @(negedge clock);
        end
        chk("instr_done", 32'(n_cyc < 20), 32'd1);
        alu_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] tr;
        int          npc, nwe, ndre, ndwe, nill, g;
        logic [4:0]  wa;
        logic [1:0]  ws;
        logic [31:0] sv;

        vt[0]  = '{32'h28400005,          1'b0, 0, 24'o1235,     1, 5'd1,  2'd0, 32'd0, 0, 0, 0};
        vt[1]  = '{mk(5'd0, 5'd21, 5'd0), 1'b1, 0, 24'o1235,     1, 5'd30, 2'd2, 32'd1, 0, 0, 0};
        vt[2]  = '{mk(5'd5, 5'd3, 5'd0),  1'b1, 0, 24'o1235,     1, 5'd30, 2'd2, 32'd2, 0, 0, 0};
        vt[3]  = '{mk(5'd0, 5'd4, 5'd1),  1'b1, 0, 24'o1235,     1, 5'd30, 2'd2, 32'd3, 0, 0, 0};
        vt[4]  = '{mk(5'd0, 5'd5, 5'd4),  1'b1, 0, 24'o1235,     1, 5'd5,  2'd0, 32'd0, 0, 0, 0};
        vt[5]  = '{mk(5'd0, 5'd6, 5'd2),  1'b0, 0, 24'o1235,     1, 5'd6,  2'd0, 32'd0, 0, 0, 0};
        vt[6]  = '{mk(5'd8, 5'd7, 5'd0),  1'b0, 3, 24'o12344445, 1, 5'd7,  2'd1, 32'd0, 4, 0, 0};
        vt[7]  = '{mk(5'd7, 5'd8, 5'd0),  1'b0, 1, 24'o12344,    0, 5'd0,  2'd0, 32'd0, 0, 2, 0};
        vt[8]  = '{mk(5'd7, 5'd9, 5'd0),  1'b0, 0, 24'o1234,     0, 5'd0,  2'd0, 32'd0, 0, 1, 0};
        vt[9]  = '{mk(5'd31, 5'd10, 5'd0),1'b0, 0, 24'o12,       0, 5'd0,  2'd0, 32'd0, 0, 0, 1};
        vt[10] = '{mk(5'd0, 5'd0, 5'd0),  1'b0, 0, 24'o1235,     0, 5'd0,  2'd0, 32'd0, 0, 0, 0};
        vt[11] = '{mk(5'd0, 5'd0, 5'd1),  1'b1, 0, 24'o1235,     1, 5'd30, 2'd2, 32'd3, 0, 0, 0};
        vt[12] = '{mk(5'd8, 5'd0, 5'd0),  1'b0, 0, 24'o12345,    0, 5'd0,  2'd0, 32'd0, 1, 0, 0};
        vt[13] = '{mk(5'd1, 5'd11, 5'd0), 1'b0, 0, 24'o12,       0, 5'd0,  2'd0, 32'd0, 0, 0, 1};
        vt[14] = '{mk(5'd0, 5'd12, 5'd5), 1'b1, 0, 24'o1235,     1, 5'd12, 2'd0, 32'd0, 0, 0, 0};
        vt[15] = '{mk(5'd8, 5'd13, 5'd0), 1'b1, 0, 24'o12345,    1, 5'd13, 2'd1, 32'd0, 1, 0, 0};

        // Reset held for two cycles.
        reset = 1'b0; run = 1'b0; instr = '0; dmem_ready = 1'b0; alu_ovf = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", 32'({pc_en, ir_load, rf_re, alu_en, dmem_re, dmem_we, rf_we, illegal}), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wbsel", 32'(wb_sel), 32'd0);
        chk("rst_status", status_val, 32'd0);
`ifdef MC_CTRL_PERF_CNT_EN
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
`endif
        reset = 1'b1;
        @(negedge clock);
        chk("idle_hold_no_run", 32'(state_o), 32'd0);
        run = 1'b1;

        for (int i = 0; i < 16; i++) begin
            exec_instr(vt[i].ins, vt[i].ovf, vt[i].waits, 1'b0, tr, npc, nwe, ndre, ndwe,
                       nill, wa, ws, sv);
            chk($sformatf("v%0d_trace", i), 32'(tr), 32'(vt[i].trace));
            chk($sformatf("v%0d_pc_en", i), 32'(npc), 32'd1);
            chk($sformatf("v%0d_rf_we", i), 32'(nwe), 32'(vt[i].we));
            if (vt[i].we != 0) begin
                chk($sformatf("v%0d_waddr", i), 32'(wa), 32'(vt[i].wa));
                chk($sformatf("v%0d_wbsel", i), 32'(ws), 32'(vt[i].ws));
                if (vt[i].ws == 2'd2) chk($sformatf("v%0d_status", i), sv, vt[i].sv);
            end
            chk($sformatf("v%0d_dmem_re", i), 32'(ndre), 32'(vt[i].dre));
            chk($sformatf("v%0d_dmem_we", i), 32'(ndwe), 32'(vt[i].dwe));
            chk($sformatf("v%0d_illegal", i), 32'(nill), 32'(vt[i].ill));
        end

        // run dropped in EXEC: WB still completes, then IDLE.
        exec_instr(mk(5'd0, 5'd14, 5'd3), 1'b0, 0, 1'b1, tr, npc, nwe, ndre, ndwe, nill,
                   wa, ws, sv);
        chk("drop_trace", 32'(tr), 32'(24'o1235));
        chk("drop_rf_we", 32'(nwe), 32'd1);
        chk("drop_waddr", 32'(wa), 32'd14);
        chk("drop_idle", 32'(state_o), 32'd0);
        @(negedge clock);
        chk("drop_idle_hold", 32'(state_o), 32'd0);
        chk("drop_no_fetch", 32'(pc_en), 32'd0);

        // Reset asserted mid-cycle while a sw waits in MEM.
        instr = mk(5'd7, 5'd9, 5'd0);
        dmem_ready = 1'b0;
        run = 1'b1;
        g = 0;
        while (state_o != 3'd4 && g < 10) begin
            @(negedge clock);
            g++;
        end
        chk("mem_reached", 32'(state_o), 32'd4);
        chk("mem_dmem_we", 32'(dmem_we), 32'd1);
        chk("mem_waddr", 32'(rf_waddr), 32'd9);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 32'd0);
        chk("arst_dmem_we", 32'(dmem_we), 32'd0);
        chk("arst_rf_we", 32'(rf_we), 32'd0);
        chk("arst_waddr", 32'(rf_waddr), 32'd0);
        run = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("arst_stay_idle", 32'(state_o), 32'd0);

`ifdef MC_CTRL_PERF_CNT_EN
        // Three ALU instructions and a no-wait sw from a fresh reset.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exec_instr(mk(5'd5, 5'(k + 1), 5'd0), 1'b0, 0, 1'b0, tr, npc, nwe, ndre, ndwe,
                       nill, wa, ws, sv);
        end
        exec_instr(mk(5'd7, 5'd2, 5'd0), 1'b0, 0, 1'b1, tr, npc, nwe, ndre, ndwe, nill,
                   wa, ws, sv);
        chk("perf_idle", 32'(state_o), 32'd0);
        chk("perf_cycle_cnt", cycle_cnt, 32'd16);
        chk("perf_retire_cnt", retire_cnt, 32'd4);
        @(negedge clock);
        chk("perf_cycle_hold", cycle_cnt, 32'd16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
